// File: rtl/operand_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operand_loader_pkg                                              |
// | Brief    : Shared state encoding and counter sizing for operand_loader.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package operand_loader_pkg;

    localparam int c_state_w = 3;

    // CHECK is only reachable when OPERAND_LOADER_PARITY_EN is defined.
    typedef enum logic [c_state_w-1:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        PRESENT = 3'd3,
        CHECK   = 3'd4
    } state_t;

    // Bits needed to count 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ser_shift_reg                                                   |
// | Brief    : LSB-first serial-in / parallel-out shift register with clear.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // New bits enter at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= {ser_in, r_q[WIDTH-1:1]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operand_loader                                                  |
// | Brief    : Serially collects operand A then B (LSB first) and presents     |
// |            them with carry-in over a valid/ready handshake.                |
// | Options  : OPERAND_LOADER_PARITY_EN adds a parity CHECK state and the      |
// |            parity_err output.                                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin_in,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             cin,
    output logic             op_valid,
`ifdef OPERAND_LOADER_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int                 c_cnt_w    = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cin;
    logic               w_clr;
    logic               w_shift_a;
    logic               w_shift_b;
    logic               w_last_bit;

    // The bit being accepted this cycle completes the current operand.
    assign w_last_bit = ser_valid && (r_cnt == c_last_bit);

`ifdef OPERAND_LOADER_PARITY_EN
    logic w_parity_ok;
    logic r_parity_err;

    // The parity bit reads 1 when A and B together hold an even number of ones.
    assign w_parity_ok = (ser_in == ~^{op_a, op_b});
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD_A;
                end
            end
            LOAD_A: begin
                if (w_last_bit) begin
                    w_next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_last_bit) begin
`ifdef OPERAND_LOADER_PARITY_EN
                    w_next_state = CHECK;
`else
                    w_next_state = PRESENT;
`endif
                end
            end
            PRESENT: begin
                // start is not looked at here, so IDLE always lasts at least one cycle.
                if (op_ready) begin
                    w_next_state = IDLE;
                end
            end
`ifdef OPERAND_LOADER_PARITY_EN
            CHECK: begin
                if (ser_valid) begin
                    w_next_state = w_parity_ok ? PRESENT : IDLE;
                end
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output and datapath-control decode from the current state.
    always_comb begin
        op_valid  = (r_state == PRESENT);
        busy      = (r_state != IDLE);
        w_clr     = (r_state == IDLE) && start;
        w_shift_a = (r_state == LOAD_A) && ser_valid;
        w_shift_b = (r_state == LOAD_B) && ser_valid;
    end

    // Bit counter: cleared on every state change so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (w_shift_a || w_shift_b) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // Carry-in is latched only when a load is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cin <= 1'b0;
        end else if (w_clr) begin
            r_cin <= cin_in;
        end
    end

    assign cin = r_cin;

`ifdef OPERAND_LOADER_PARITY_EN
    // One-cycle error pulse coinciding with the return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_state == CHECK) && ser_valid && !w_parity_ok;
        end
    end

    assign parity_err = r_parity_err;
`endif

    ser_shift_reg #(
        .WIDTH    (WIDTH)
    ) u_shift_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift_a),
        .ser_in   (ser_in),
        .q        (op_a)
    );

    ser_shift_reg #(
        .WIDTH    (WIDTH)
    ) u_shift_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift_b),
        .ser_in   (ser_in),
        .q        (op_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_operand_loader                                               |
// | Brief    : Directed self-checking bench for operand_loader (WIDTH=4).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_operand_loader;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cin_in;
    logic             ser_in;
    logic             ser_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             op_valid;
    logic             busy;
`ifdef OPERAND_LOADER_PARITY_EN
    logic             parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] a_val = 4'hB;
    logic [WIDTH-1:0] b_val = 4'h6;

    operand_loader #(
        .WIDTH      (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cin_in     (cin_in),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .op_valid   (op_valid),
`ifdef OPERAND_LOADER_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted bit, optionally preceded by an idle cycle carrying a junk 1.
    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            ser_valid = 1'b0;
            ser_in    = 1'b1;
            tick();
        end
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v, input bit gap);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(v[i], gap);
        end
    endtask

    // Parity bit 0 is the correct one for A=B, B=6 (five ones in total).
    task automatic send_good_parity();
`ifdef OPERAND_LOADER_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
    endtask

    task automatic do_start(input logic c);
        start  = 1'b1;
        cin_in = c;
        tick();
        start  = 1'b0;
        cin_in = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cin_in    = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        op_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_cin", cin, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_busy", busy, 0);

        // Case 1: asynchronous reset in the middle of loading A
        do_start(1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t1_partial_a", op_a, 4'hC);
        check("t1_busy_pre", busy, 1);
        check("t1_cin_pre", cin, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_op_a", op_a, 0);
        check("t1_async_cin", cin, 0);
        check("t1_async_busy", busy, 0);
        check("t1_async_op_valid", op_valid, 0);
        #1 rst = 1'b0;
        tick();
        check("t1_idle_after", busy, 0);

        // Case 2: back-to-back bits, op_ready high
        op_ready = 1'b1;
        do_start(1'b1);
        check("t2_busy", busy, 1);
        send_word(a_val, 1'b0);
        check("t2_a_done_op_a", op_a, 4'hB);
        for (int i = 0; i < WIDTH - 1; i++) begin
            send_bit(b_val[i], 1'b0);
        end
        check("t2_not_valid_early", op_valid, 0);
        send_bit(b_val[WIDTH-1], 1'b0);
        send_good_parity();
        check("t2_op_valid", op_valid, 1);
        check("t2_op_a", op_a, 4'hB);
        check("t2_op_b", op_b, 4'h6);
        check("t2_cin", cin, 1);
        tick();
        check("t2_valid_one_cycle", op_valid, 0);
        check("t2_idle", busy, 0);
        check("t2_op_a_held_idle", op_a, 4'hB);
        check("t2_op_b_held_idle", op_b, 4'h6);

        // Case 3: backpressure for 5 cycles, cin=0, ser_valid noise in PRESENT
        op_ready = 1'b0;
        do_start(1'b0);
        check("t3_clr_op_a", op_a, 0);
        check("t3_clr_op_b", op_b, 0);
        send_word(a_val, 1'b0);
        send_word(b_val, 1'b0);
        send_good_parity();
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", op_valid, 1);
            check("t3_hold_op_a", op_a, 4'hB);
            check("t3_hold_op_b", op_b, 4'h6);
            check("t3_hold_cin", cin, 0);
            ser_valid = 1'b1;
            ser_in    = k[0];
            tick();
        end
        ser_valid = 1'b0;
        check("t3_still_valid", op_valid, 1);
        op_ready = 1'b1;
        tick();
        check("t3_drop_valid", op_valid, 0);
        check("t3_op_a_after", op_a, 4'hB);
        check("t3_op_b_after", op_b, 4'h6);

        // Case 4: every other cycle ser_valid low (junk on ser_in during gaps)
        do_start(1'b1);
        send_word(a_val, 1'b1);
        check("t4_gap_op_a", op_a, 4'hB);
        for (int i = 0; i < WIDTH - 1; i++) begin
            send_bit(b_val[i], 1'b1);
        end
        ser_valid = 1'b0;
        ser_in    = 1'b1;
        tick();
        check("t4_not_valid_early", op_valid, 0);
        send_bit(b_val[WIDTH-1], 1'b0);
        send_good_parity();
        check("t4_op_valid", op_valid, 1);
        check("t4_op_a", op_a, 4'hB);
        check("t4_op_b", op_b, 4'h6);
        tick();

        // Case 5: start during LOAD_B and on the handshake cycle
        op_ready = 1'b0;
        do_start(1'b0);
        send_word(a_val, 1'b0);
        start = 1'b1;
        send_word(b_val, 1'b0);
        start = 1'b0;
        send_good_parity();
        check("t5_valid", op_valid, 1);
        check("t5_op_a", op_a, 4'hB);
        check("t5_op_b", op_b, 4'h6);
        op_ready = 1'b1;
        start    = 1'b1;
        cin_in   = 1'b1;
        tick();
        start  = 1'b0;
        cin_in = 1'b0;
        check("t5_hs_idle", busy, 0);
        check("t5_hs_valid", op_valid, 0);
        tick();
        check("t5_no_new_load", busy, 0);
        check("t5_cin_kept", cin, 0);
        check("t5_op_a_kept", op_a, 4'hB);

`ifdef OPERAND_LOADER_PARITY_EN
        // Case 6: wrong parity bit, then correct parity bit
        do_start(1'b0);
        send_word(a_val, 1'b0);
        send_word(b_val, 1'b0);
        check("t6_in_check", busy, 1);
        send_bit(1'b1, 1'b0);
        check("t6_perr_pulse", parity_err, 1);
        check("t6_perr_no_valid", op_valid, 0);
        check("t6_perr_idle", busy, 0);
        tick();
        check("t6_perr_clear", parity_err, 0);
        check("t6_perr_still_no_valid", op_valid, 0);
        do_start(1'b1);
        send_word(a_val, 1'b0);
        send_word(b_val, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t6_ok_valid", op_valid, 1);
        check("t6_ok_perr", parity_err, 0);
        check("t6_ok_op_a", op_a, 4'hB);
        tick();
        check("t6_ok_done", op_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
